// File: rtl/inst_fetcher_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetcher_pkg                                                           |
// | Opcode constants, fetch FSM encoding and J-immediate decode helper.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package inst_fetcher_pkg;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_MISS  = 2'd1,
        ST_OUT   = 2'd2,
        ST_STALL = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icache_dm                                                                  |
// | Direct-mapped one-word-per-line instruction cache, async lookup, sync fill.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icache_dm #(
    parameter int IDX_W = 4,
    localparam int TAG_W = 30 - IDX_W,
    localparam int LINES = 2 ** IDX_W
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [IDX_W-1:0]  lookup_idx,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [31:0]       hit_data,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [31:0]       fill_data
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Only the valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid <= '0;
        end else if (fill_en) begin
            r_valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            r_tag[fill_idx]  <= fill_tag;
            r_data[fill_idx] <= fill_data;
        end
    end

    assign hit      = r_valid[lookup_idx] && (r_tag[lookup_idx] == lookup_tag);
    assign hit_data = r_data[lookup_idx];

endmodule
`default_nettype wire

// File: rtl/inst_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetcher                                                               |
// | Instruction fetch FSM with JAL prediction and JALR stall; optional icache  |
// | enabled by macro INST_FETCHER_ICACHE_EN.                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          ICACHE_IDX_W = 4,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        mem_inst_ready_in,
    input  logic [31:0] mem_inst_in,
    output logic        mem_need_inst_out,
    output logic [31:0] mem_pc_out,
    output logic        stall_set_out,
    input  logic        stall_recover_in,
    input  logic [31:0] resume_pc_in,
    input  logic        clear_in,
    input  logic [31:0] redirect_pc_in,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        pred_taken_out,
    input  logic        issue_ready_in
);

    if (ICACHE_IDX_W < 1 || ICACHE_IDX_W > 28) begin : g_bad_idx_w
        $error("ICACHE_IDX_W out of range");
    end

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_mem_need, w_mem_need_nxt;
    logic [31:0]  r_mem_pc, w_mem_pc_nxt;
    logic         r_inst_valid, w_inst_valid_nxt;
    logic [31:0]  r_inst, w_inst_nxt;
    logic [31:0]  r_pc_out, w_pc_out_nxt;
    logic         r_pred, w_pred_nxt;
    logic         w_stall_set;
    logic         w_hit;
    logic [31:0]  w_hit_data;

`ifdef INST_FETCHER_ICACHE_EN
    logic w_fill_en;

    // A word arriving during a flush is dropped, so it must never reach the cache.
    assign w_fill_en = rdy_in && !clear_in && (r_state == ST_MISS) && mem_inst_ready_in;

    icache_dm #(
        .IDX_W (ICACHE_IDX_W)
    ) u_icache (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .lookup_idx (r_pc[ICACHE_IDX_W+1:2]),
        .lookup_tag (r_pc[31:ICACHE_IDX_W+2]),
        .hit        (w_hit),
        .hit_data   (w_hit_data),
        .fill_en    (w_fill_en),
        .fill_idx   (r_pc[ICACHE_IDX_W+1:2]),
        .fill_tag   (r_pc[31:ICACHE_IDX_W+2]),
        .fill_data  (mem_inst_in)
    );
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 32'h0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_mem_need   <= 1'b0;
            r_mem_pc     <= 32'h0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'h0;
            r_pc_out     <= 32'h0;
            r_pred       <= 1'b0;
        end else if (rdy_in) begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_mem_need   <= w_mem_need_nxt;
            r_mem_pc     <= w_mem_pc_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_pred       <= w_pred_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_mem_need_nxt   = r_mem_need;
        w_mem_pc_nxt     = r_mem_pc;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_nxt       = r_inst;
        w_pc_out_nxt     = r_pc_out;
        w_pred_nxt       = r_pred;
        w_stall_set      = 1'b0;

        if (clear_in) begin
            w_state_nxt      = ST_FETCH;
            w_pc_nxt         = redirect_pc_in;
            w_mem_need_nxt   = 1'b0;
            w_inst_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_hit) begin
                        w_state_nxt      = ST_OUT;
                        w_inst_valid_nxt = 1'b1;
                        w_inst_nxt       = w_hit_data;
                        w_pc_out_nxt     = r_pc;
                        w_pred_nxt       = (w_hit_data[6:0] == OPC_JAL);
                    end else begin
                        w_state_nxt    = ST_MISS;
                        w_mem_need_nxt = 1'b1;
                        w_mem_pc_nxt   = r_pc;
                    end
                end
                ST_MISS: begin
                    if (mem_inst_ready_in) begin
                        w_state_nxt      = ST_OUT;
                        w_mem_need_nxt   = 1'b0;
                        w_inst_valid_nxt = 1'b1;
                        w_inst_nxt       = mem_inst_in;
                        w_pc_out_nxt     = r_pc;
                        w_pred_nxt       = (mem_inst_in[6:0] == OPC_JAL);
                    end
                end
                ST_OUT: begin
                    if (issue_ready_in) begin
                        w_inst_valid_nxt = 1'b0;
                        if (r_inst[6:0] == OPC_JALR) begin
                            w_state_nxt = ST_STALL;
                            w_stall_set = 1'b1;
                            w_pc_nxt    = r_pc + 32'd4;
                        end else begin
                            w_state_nxt = ST_FETCH;
                            w_pc_nxt    = r_pc + (r_pred ? j_imm(r_inst) : 32'd4);
                        end
                    end
                end
                ST_STALL: begin
                    if (stall_recover_in) begin
                        w_state_nxt = ST_FETCH;
                        w_pc_nxt    = resume_pc_in;
                    end
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end
    end

    assign mem_need_inst_out = r_mem_need;
    assign mem_pc_out        = r_mem_pc;
    assign inst_valid_out    = r_inst_valid;
    assign inst_out          = r_inst;
    assign pc_out            = r_pc_out;
    assign pred_taken_out    = r_pred;
    assign stall_set_out     = w_stall_set && rdy_in;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_fetcher                                                            |
// | Randomized bench against an instruction-stream reference model.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inst_fetcher;

    localparam int          IW       = 4;
    localparam logic [31:0] RST_PC   = 32'h0;
    localparam int          N_CYCLES = 4000;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        mem_inst_ready_in;
    logic [31:0] mem_inst_in;
    logic        mem_need_inst_out;
    logic [31:0] mem_pc_out;
    logic        stall_set_out;
    logic        stall_recover_in;
    logic [31:0] resume_pc_in;
    logic        clear_in;
    logic [31:0] redirect_pc_in;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        pred_taken_out;
    logic        issue_ready_in;

    always #5 clk_in = ~clk_in;

    inst_fetcher #(
        .ICACHE_IDX_W (IW),
        .RESET_PC     (RST_PC)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .rdy_in            (rdy_in),
        .mem_inst_ready_in (mem_inst_ready_in),
        .mem_inst_in       (mem_inst_in),
        .mem_need_inst_out (mem_need_inst_out),
        .mem_pc_out        (mem_pc_out),
        .stall_set_out     (stall_set_out),
        .stall_recover_in  (stall_recover_in),
        .resume_pc_in      (resume_pc_in),
        .clear_in          (clear_in),
        .redirect_pc_in    (redirect_pc_in),
        .inst_valid_out    (inst_valid_out),
        .inst_out          (inst_out),
        .pc_out            (pc_out),
        .pred_taken_out    (pred_taken_out),
        .issue_ready_in    (issue_ready_in)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Program image: kind 0 = plain, 1 = JAL (offset in prog_off), 2 = JALR.
    logic [31:0] prog     [64];
    int          prog_kind[64];
    logic [31:0] prog_off [64];

    // Reference model state
    logic [31:0] exp_pc;
    bit          stalled;
    int          fstage;   // 1: in FETCH, 2: FETCH decision due, 3: fill delivered
    int          idle;
    int          lat;
    bit          want_reset;
    bit          cv[1<<IW];
    logic [29-IW:0] ct[1<<IW];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return prog[a[7:2]];
    endfunction

    function automatic int kind_at(input logic [31:0] a);
        return prog_kind[a[7:2]];
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
`ifdef INST_FETCHER_ICACHE_EN
        return cv[a[IW+1:2]] && (ct[a[IW+1:2]] == a[31:IW+2]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic gen_program();
        for (int i = 0; i < 64; i++) begin
            int r;
            int o;
            logic [20:0] imm;
            r = int'($urandom_range(0, 99));
            prog_off[i] = 32'd4;
            if (r < 15) begin
                o = int'($urandom_range(0, 16)) - 8;
                if (o == 0) o = 2;
                o = o * 4;
                imm = 21'(o);
                prog[i]      = {imm[20], imm[10:1], imm[11], imm[19:12], 5'($urandom), 7'b1101111};
                prog_kind[i] = 1;
                prog_off[i]  = 32'(o);
            end else if (r < 25) begin
                prog[i]      = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b1100111};
                prog_kind[i] = 2;
            end else begin
                prog[i]      = {25'($urandom), (r[0] ? 7'b0010011 : 7'b0110011)};
                prog_kind[i] = 0;
            end
        end
        prog[0] = 32'h00000013; prog_kind[0] = 0;
        prog[1] = 32'h00000013; prog_kind[1] = 0;
        prog[2] = 32'h0080006F; prog_kind[2] = 1; prog_off[2] = 32'd8;
        prog[3] = 32'h00008067; prog_kind[3] = 2;
    endtask

    task automatic quiet_inputs();
        rdy_in            = 1'b1;
        mem_inst_ready_in = 1'b0;
        mem_inst_in       = 32'h0;
        stall_recover_in  = 1'b0;
        resume_pc_in      = 32'h0;
        clear_in          = 1'b0;
        redirect_pc_in    = 32'h0;
        issue_ready_in    = 1'b0;
    endtask

    task automatic model_reset();
        exp_pc  = RST_PC;
        stalled = 1'b0;
        fstage  = 2;
        idle    = 0;
        lat     = 4;
        for (int i = 0; i < (1 << IW); i++) cv[i] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string p);
        check_value({p, "_need"},  32'(mem_need_inst_out), 32'h0);
        check_value({p, "_mpc"},   mem_pc_out,             32'h0);
        check_value({p, "_valid"}, 32'(inst_valid_out),    32'h0);
        check_value({p, "_inst"},  inst_out,               32'h0);
        check_value({p, "_pc"},    pc_out,                 32'h0);
        check_value({p, "_pred"},  32'(pred_taken_out),    32'h0);
        check_value({p, "_stall"}, 32'(stall_set_out),     32'h0);
    endtask

    task automatic check_outputs();
        if (fstage == 1) begin
            check_value("fetch_quiet", 32'({mem_need_inst_out, inst_valid_out}), 32'h0);
        end else if (fstage == 2) begin
            check_value("fetch_hit_valid", 32'(inst_valid_out),    32'(model_hit(exp_pc)));
            check_value("fetch_miss_req",  32'(mem_need_inst_out), 32'(!model_hit(exp_pc)));
            fstage = 0;
        end else if (fstage == 3) begin
            check_value("fill_to_out", 32'({mem_need_inst_out, inst_valid_out}), 32'h1);
            fstage = 0;
        end
        if (mem_need_inst_out) check_value("req_pc", mem_pc_out, exp_pc);
        if (inst_valid_out) begin
            check_value("inst_pc",    pc_out,                exp_pc);
            check_value("inst_word",  inst_out,              mem_word(exp_pc));
            check_value("pred_taken", 32'(pred_taken_out),   32'(kind_at(exp_pc) == 1));
        end
        if (stalled) check_value("stall_quiet", 32'({mem_need_inst_out, inst_valid_out}), 32'h0);
        if (idle > 200) begin
            check_value("progress", 32'(idle), 32'h0);
            idle = 0;
        end
    endtask

    task automatic drive_inputs();
        rdy_in   = ($urandom_range(0, 9) != 0);
        clear_in = ($urandom_range(0, 39) == 0);
        case ($urandom_range(0, 3))
            0:       redirect_pc_in = 32'($urandom_range(0, 63)) << 2;
            1:       redirect_pc_in = 32'hFFFF_FFF8;
            2:       redirect_pc_in = 32'h100;
            default: redirect_pc_in = 32'h40;
        endcase
        issue_ready_in   = clear_in ? 1'b0 : ($urandom_range(0, 9) < 6);
        stall_recover_in = stalled ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        resume_pc_in     = $urandom_range(0, 1) ? 32'h100 : (32'($urandom_range(0, 63)) << 2);
        if (mem_need_inst_out) begin
            if (lat == 0) begin
                mem_inst_ready_in = 1'b1;
                mem_inst_in       = mem_word(mem_pc_out);
            end else begin
                lat--;
                mem_inst_ready_in = 1'b0;
                mem_inst_in       = $urandom;
            end
        end else begin
            lat               = int'($urandom_range(0, 4));
            mem_inst_ready_in = ($urandom_range(0, 3) == 0);
            mem_inst_in       = $urandom;
        end
    endtask

    task automatic update_model();
        if (!rdy_in) return;
        if (clear_in) begin
            exp_pc  = redirect_pc_in;
            stalled = 1'b0;
            fstage  = 1;
            idle++;
        end else if (mem_need_inst_out && mem_inst_ready_in) begin
            cv[exp_pc[IW+1:2]] = 1'b1;
            ct[exp_pc[IW+1:2]] = exp_pc[31:IW+2];
            fstage = 3;
            idle++;
        end else if (inst_valid_out && issue_ready_in) begin
            idle = 0;
            if (kind_at(exp_pc) == 2) begin
                stalled = 1'b1;
                fstage  = 0;
            end else begin
                exp_pc = exp_pc + ((kind_at(exp_pc) == 1) ? prog_off[exp_pc[7:2]] : 32'd4);
                fstage = 1;
            end
        end else if (stalled && stall_recover_in) begin
            exp_pc  = resume_pc_in;
            stalled = 1'b0;
            fstage  = 1;
            idle    = 0;
        end else begin
            if (fstage == 1) fstage = 2;
            if (!stalled) idle++;
        end
    endtask

    initial begin
        gen_program();
        want_reset = 1'b0;
        rst_n_in   = 1'b0;
        quiet_inputs();
        model_reset();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs("rst");
        rst_n_in = 1'b1;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk_in);
            check_outputs();
            if (want_reset && mem_need_inst_out) begin
                // Asynchronous reset in the middle of an outstanding miss.
                #2 rst_n_in = 1'b0;
                #1 check_reset_outputs("mid_rst");
                @(negedge clk_in);
                quiet_inputs();
                rst_n_in = 1'b1;
                model_reset();
                want_reset = 1'b0;
                continue;
            end
            drive_inputs();
            #1;
            check_value("stall_set", 32'(stall_set_out),
                        32'(rdy_in && inst_valid_out && issue_ready_in && !clear_in
                            && kind_at(exp_pc) == 2));
            update_model();
            if (cyc == N_CYCLES / 2) want_reset = 1'b1;
        end
        check_value("mid_reset_done", 32'(want_reset), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have parameter ICACHE_IDX_W, default 4: icache index bits (2**ICACHE_IDX_W one-word lines).
REQ-002 SHALL have parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-003 SHALL have ports, clock and reset first:
 clk_in  input  1  system clock; all state on rising edge.
 rst_n_in  input  1  reset, asynchronous, active-low.
 rdy_in  input  1  ready; low freezes all state.
 mem_inst_ready_in  input  1  memory word valid this cycle.
 mem_inst_in  input  32  instruction word from memory.
 mem_need_inst_out  output  1  fetch request to memory controller.
 mem_pc_out  output  32  fetch address.
 stall_set_out  output  1  one-cycle pulse: JALR issued, halt memory fetch.
 stall_recover_in  input  1  JALR resolved.
 resume_pc_in  input  32  target accompanying stall_recover_in.
 clear_in  input  1  pipeline flush from ROB.
 redirect_pc_in  input  32  target accompanying clear_in.
 inst_valid_out  output  1  instruction presented to decoder.
 inst_out  output  32  instruction.
 pc_out  output  32  its address.
 pred_taken_out  output  1  instruction was predicted taken.
 issue_ready_in  input  1  decoder accepts this cycle.

Function
REQ-004 SHALL run FSM states FETCH, MISS, OUT, STALL.
REQ-005 FETCH: icache lookup on pc; hit -> OUT next cycle; miss -> MISS, mem_need_inst_out=1, mem_pc_out=pc.
REQ-006 MISS: hold mem_need_inst_out and mem_pc_out stable until mem_inst_ready_in; then write line (valid, tag=pc[31:ICACHE_IDX_W+2], data) and enter OUT next cycle.
REQ-007 OUT: inst_valid_out=1; inst_out/pc_out/pred_taken_out stable until issue_ready_in; transfer on inst_valid_out && issue_ready_in.
REQ-008 On transfer, next pc: JAL (opcode 7'b1101111) -> pc+sext(J-imm), pred_taken_out=1; all else pc+4, pred_taken_out=0; 32-bit wrap-around, no carry-out.
REQ-009 On transfer of JALR (opcode 7'b1100111): stall_set_out=1 same cycle, enter STALL; no request until stall_recover_in.
REQ-010 STALL: on stall_recover_in, pc<=resume_pc_in, enter FETCH next cycle.
REQ-011 clear_in SHALL win over every other event: pc<=redirect_pc_in, state<=FETCH, inst_valid_out=0 and mem_need_inst_out=0 next cycle, any in-flight memory word discarded (not written to cache).
REQ-012 mem_inst_ready_in outside MISS SHALL be ignored.
REQ-013 stall_recover_in outside STALL SHALL be ignored; simultaneous clear_in and stall_recover_in -> redirect_pc_in used.
REQ-014 rdy_in low SHALL hold every register including outputs; clear_in ignored while rdy_in low.
REQ-015 Latency: hit 1 cycle FETCH->inst_valid_out; miss = memory latency + 1.

Reset
REQ-016 On rst_n_in low, asynchronously: pc=RESET_PC, state=FETCH, all cache valid bits 0, all outputs 0.
REQ-017 Reset mid-MISS SHALL abandon the fetch; first request after release is RESET_PC.

Configuration
REQ-018 Macro INST_FETCHER_ICACHE_EN defined: icache per REQ-005/006.
REQ-019 Macro undefined: no cache storage; FETCH always behaves as miss; all other behaviour identical.

Structure
REQ-020 Shared package SHALL hold opcode constants (OPC_JAL, OPC_JALR), FSM state encodings, and J-immediate extraction function.
REQ-021 One sub-module icache_dm (direct-mapped tag/data/valid array, lookup + fill ports), instantiated only under INST_FETCHER_ICACHE_EN.

Verification
REQ-022 Reset release, memory returns 32'h00000013 at pc 0 after 4 cycles -> mem_pc_out=0, inst_valid_out with inst_out=32'h00000013, pc_out=0; next request pc 4.
REQ-023 Loop back to pc 0 (cache enabled) -> inst_valid_out 1 cycle after FETCH, mem_need_inst_out stays 0.
REQ-024 JAL 32'h0080006F at pc 8 accepted -> next pc 16, pred_taken_out=1.
REQ-025 JALR at pc 12 accepted -> stall_set_out single pulse, no request; stall_recover_in with resume_pc_in=32'h100 -> next mem_pc_out=32'h100.
REQ-026 clear_in with redirect_pc_in=32'h40 during MISS, stale mem_inst_ready_in next cycle -> word discarded, not cached, next request 32'h40.
REQ-027 issue_ready_in low 5 cycles in OUT, rdy_in low 2 cycles -> outputs unchanged, exactly one transfer.
